// File: rtl/apb_tmr32_seq.sv
// apb_tmr32_seq
//   APB-programmable sequencer that walks a table of (CMP, LOAD[, PRE]) entries,
//   presenting one entry per timer period to an external 32-bit timer core.
//
// Parameters
//   DEPTH : number of table entries (2..16)
//   IW    : index width, 2**IW >= DEPTH
//
// Ports
//   PCLK, PRESETn              : clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY : APB slave (PRDATA combinational)
//   PIRQ                       : |(IM & {WRAP, DONE})
//   TMR_EN/TMR_LOAD/TMR_CMP/TMR_PRE/TMR_OVF_CLR : timer core controls
//   TMR_OVF                    : timer overflow flag (level)
//
// Build option
//   TMR_SEQ_PRESCALE_EN : adds a 16-bit per-entry prescaler field (WPRE at 0x48)
module apb_tmr32_seq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PIRQ,
  output logic        TMR_EN,
  output logic [31:0] TMR_LOAD,
  output logic [31:0] TMR_CMP,
  output logic [15:0] TMR_PRE,
  output logic        TMR_OVF_CLR,
  input  logic        TMR_OVF
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_ADV   = 2'd3
  } state_t;

  localparam int unsigned   NENT     = 1 << IW;
  localparam logic [IW:0]   DEPTH_C  = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_STATUS = 5'd1;
  localparam logic [4:0] A_COUNT  = 5'd2;
  localparam logic [4:0] A_REPEAT = 5'd3;
  localparam logic [4:0] A_WIDX   = 5'd4;
  localparam logic [4:0] A_WCMP   = 5'd5;
  localparam logic [4:0] A_WLOAD  = 5'd6;
  localparam logic [4:0] A_IM     = 5'd7;
  localparam logic [4:0] A_IC     = 5'd8;
  localparam logic [4:0] A_WPRE   = 5'd9;

  logic [4:0] sel;
  logic       wr;
  logic       unused_paddr;

  assign sel          = PADDR[7:3];
  assign wr           = PSEL & PENABLE & PWRITE;
  assign unused_paddr = ^PADDR[2:0];

  state_t      state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]  pass_q, pass_d;
  logic [IW:0] count_q, count_d;
  logic [7:0]  repeat_q, repeat_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [1:0]  im_q, im_d;
  logic        done_q, done_d;
  logic        wrap_q, wrap_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] load_q, load_d;
  logic [1:0]  ic_clr;
  logic        done_set, wrap_set;

  // Table storage is sized to the full index range so any ptr value is a legal index.
  logic [31:0] cmp_mem  [NENT];
  logic [31:0] load_mem [NENT];

  always_ff @(posedge PCLK) begin
    if (wr && sel == A_WCMP)  cmp_mem[widx_q]  <= PWDATA;
    if (wr && sel == A_WLOAD) load_mem[widx_q] <= PWDATA;
  end

  // Register file
  always_comb begin
    count_d  = count_q;
    repeat_d = repeat_q;
    widx_d   = widx_q;
    im_d     = im_q;
    start_d  = wr && (sel == A_CTRL) && PWDATA[0];
    stop_d   = wr && (sel == A_CTRL) && PWDATA[1];
    ic_clr   = (wr && sel == A_IC) ? PWDATA[1:0] : 2'b00;
    if (wr) begin
      case (sel)
        A_COUNT:  count_d  = (PWDATA > 32'(DEPTH)) ? DEPTH_C : PWDATA[IW:0];
        A_REPEAT: repeat_d = PWDATA[7:0];
        A_WIDX:   widx_d   = PWDATA[IW-1:0];
        A_WLOAD:  widx_d   = (widx_q == LAST_IDX) ? '0 : widx_q + IW'(1);
        A_IM:     im_d     = PWDATA[1:0];
        default:  ;
      endcase
    end
  end

  // Sequencer FSM; START/STOP act one cycle after the write via their pulse flops.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pass_d   = pass_q;
    done_set = 1'b0;
    wrap_set = 1'b0;
    if (stop_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_q && count_q != '0) begin
            state_d = S_PRIME;
            ptr_d   = '0;
            pass_d  = '0;
          end
        end
        S_PRIME: state_d = S_RUN;
        S_RUN:   if (TMR_OVF) state_d = S_ADV;
        S_ADV: begin
          if (({1'b0, ptr_q} + (IW+1)'(1)) < count_q) begin
            ptr_d   = ptr_q + IW'(1);
            state_d = S_RUN;
          end else begin
            pass_d   = pass_q + 8'd1;
            wrap_set = 1'b1;
            if (repeat_q != 8'd0 && (pass_q + 8'd1) == repeat_q) begin
              done_set = 1'b1;
              state_d  = S_IDLE;
            end else begin
              ptr_d   = '0;
              state_d = S_RUN;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // A set in the same cycle as an IC clear takes priority.
    done_d = done_set | (done_q & ~ic_clr[0]);
    wrap_d = wrap_set | (wrap_q & ~ic_clr[1]);
    cmp_d  = cmp_mem[ptr_q];
    load_d = load_mem[ptr_q];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      pass_q   <= '0;
      count_q  <= '0;
      repeat_q <= '0;
      widx_q   <= '0;
      im_q     <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      cmp_q    <= '0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pass_q   <= pass_d;
      count_q  <= count_d;
      repeat_q <= repeat_d;
      widx_q   <= widx_d;
      im_q     <= im_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      cmp_q    <= cmp_d;
      load_q   <= load_d;
    end
  end

`ifdef TMR_SEQ_PRESCALE_EN
  logic [15:0] pre_mem [NENT];
  logic [15:0] pre_q, pre_d;

  always_ff @(posedge PCLK) begin
    if (wr && sel == A_WPRE) pre_mem[widx_q] <= PWDATA[15:0];
  end

  always_comb pre_d = pre_mem[ptr_q];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) pre_q <= '0;
    else          pre_q <= pre_d;
  end

  assign TMR_PRE = pre_q;
`else
  assign TMR_PRE = '0;
`endif

  assign TMR_EN      = (state_q == S_RUN) || (state_q == S_ADV);
  assign TMR_OVF_CLR = (state_q == S_ADV);
  assign TMR_CMP     = cmp_q;
  assign TMR_LOAD    = load_q;
  assign PREADY      = 1'b1;
  assign PIRQ        = |(im_q & {wrap_q, done_q});

  always_comb begin
    PRDATA = 32'hDEAD_BEEF;
    case (sel)
      A_CTRL:   PRDATA = '0;
      A_STATUS: PRDATA = {8'h00, pass_q, 4'h0, 4'(ptr_q), 4'h0, wrap_q, done_q, state_q};
      A_COUNT:  PRDATA = 32'(count_q);
      A_REPEAT: PRDATA = {24'h0, repeat_q};
      A_WIDX:   PRDATA = 32'(widx_q);
      A_WCMP:   PRDATA = '0;
      A_WLOAD:  PRDATA = '0;
      A_IM:     PRDATA = {30'h0, im_q};
      A_IC:     PRDATA = '0;
`ifdef TMR_SEQ_PRESCALE_EN
      A_WPRE:   PRDATA = '0;
`endif
      default:  PRDATA = 32'hDEAD_BEEF;
    endcase
  end

endmodule

// File: tb/tb_apb_tmr32_seq.sv
module tb_apb_tmr32_seq;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PIRQ, TMR_EN, TMR_OVF_CLR, TMR_OVF;
  logic [31:0] TMR_LOAD, TMR_CMP;
  logic [15:0] TMR_PRE;

  apb_tmr32_seq #(.DEPTH(8), .IW(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PIRQ(PIRQ),
    .TMR_EN(TMR_EN), .TMR_LOAD(TMR_LOAD), .TMR_CMP(TMR_CMP), .TMR_PRE(TMR_PRE),
    .TMR_OVF_CLR(TMR_OVF_CLR), .TMR_OVF(TMR_OVF)
  );

  always #5 PCLK = ~PCLK;

  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h08, A_COUNT = 8'h10, A_REPEAT = 8'h18;
  localparam logic [7:0] A_WIDX = 8'h20, A_WCMP = 8'h28, A_WLOAD = 8'h30, A_IM = 8'h38;
  localparam logic [7:0] A_IC = 8'h40, A_WPRE = 8'h48;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        do_wr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] addr, output logic [31:0] data);
    PADDR = addr; PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1;
    #1;
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // One overflow pulse; returns two cycles after the ADV cycle, when the new entry is visible.
  task automatic ovf_pulse(input string name);
    TMR_OVF = 1'b1;
    @(negedge PCLK);
    check({name, "_ovfclr"}, {31'b0, TMR_OVF_CLR}, 32'd1);
    TMR_OVF = 1'b0;
    cycles(2);
  endtask

  logic [31:0] s;
  logic [31:0] exp_cmp[6]  = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20, 32'd30};
  logic [31:0] exp_load[6] = '{32'd100, 32'd200, 32'd300, 32'd100, 32'd200, 32'd300};
  logic [3:0]  exp_ptr[5]  = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, A_COUNT,  32'd31,     A_COUNT,  32'd8};
    vecs[1]  = '{1'b1, A_COUNT,  32'd5,      A_COUNT,  32'd5};
    vecs[2]  = '{1'b1, A_COUNT,  32'd8,      A_COUNT,  32'd8};
    vecs[3]  = '{1'b1, A_COUNT,  32'd9,      A_COUNT,  32'd8};
    vecs[4]  = '{1'b1, A_REPEAT, 32'h1FF,    A_REPEAT, 32'hFF};
    vecs[5]  = '{1'b1, A_WIDX,   32'd3,      A_WIDX,   32'd3};
    vecs[6]  = '{1'b1, A_WIDX,   32'd7,      A_WIDX,   32'd7};
    vecs[7]  = '{1'b1, A_WLOAD,  32'h55,     A_WIDX,   32'd0};
    vecs[8]  = '{1'b1, A_WLOAD,  32'h66,     A_WIDX,   32'd1};
    vecs[9]  = '{1'b1, A_IM,     32'd3,      A_IM,     32'd3};
    vecs[10] = '{1'b1, A_IM,     32'd0,      A_IM,     32'd0};
    vecs[11] = '{1'b0, A_CTRL,   32'd0,      A_CTRL,   32'd0};
    vecs[12] = '{1'b0, A_CTRL,   32'd0,      A_IC,     32'd0};
    vecs[13] = '{1'b0, A_CTRL,   32'd0,      8'h50,    32'hDEAD_BEEF};
`ifdef TMR_SEQ_PRESCALE_EN
    vecs[14] = '{1'b0, A_CTRL,   32'd0,      A_WPRE,   32'd0};
`else
    vecs[14] = '{1'b0, A_CTRL,   32'd0,      A_WPRE,   32'hDEAD_BEEF};
`endif
    vecs[15] = '{1'b0, A_CTRL,   32'd0,      A_STATUS, 32'd0};
    vecs[16] = '{1'b1, A_IC,     32'd3,      A_STATUS, 32'd0};

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = '0; TMR_OVF = 1'b0;
    #12;
    check("rst_en",     {31'b0, TMR_EN}, 32'd0);
    check("rst_ovfclr", {31'b0, TMR_OVF_CLR}, 32'd0);
    check("rst_cmp",    TMR_CMP, 32'd0);
    check("rst_load",   TMR_LOAD, 32'd0);
    check("rst_pre",    {16'b0, TMR_PRE}, 32'd0);
    check("rst_pirq",   {31'b0, PIRQ}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pready", {31'b0, PREADY}, 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    cycles(1);

    // Register access vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].do_wr) apb_wr(vecs[i].waddr, vecs[i].wdata);
      apb_rd(vecs[i].raddr, s);
      check($sformatf("vec%0d", i), s, vecs[i].exp);
    end

    // Program entries 0..2
    apb_wr(A_WIDX, 32'd0);
    for (int i = 0; i < 3; i++) begin
`ifdef TMR_SEQ_PRESCALE_EN
      apb_wr(A_WPRE, (i == 0) ? 32'd3 : (i == 1) ? 32'd7 : 32'd0);
`endif
      apb_wr(A_WCMP, 32'(10 * (i + 1)));
      apb_wr(A_WLOAD, 32'(100 * (i + 1)));
    end

    // Run: COUNT=3, REPEAT=2, six overflows
    apb_wr(A_COUNT, 32'd3);
    apb_wr(A_REPEAT, 32'd2);
    apb_wr(A_CTRL, 32'd1);
    cycles(1);
    apb_rd(A_STATUS, s);
    check("t1_prime_state", {30'b0, s[1:0]}, 32'd1);
    check("t1_prime_en", {31'b0, TMR_EN}, 32'd0);
    cycles(1);
    check("t1_run_en", {31'b0, TMR_EN}, 32'd1);
    check("t1_cmp0", TMR_CMP, 32'd10);
    check("t1_load0", TMR_LOAD, 32'd100);
`ifdef TMR_SEQ_PRESCALE_EN
    check("t1_pre0", {16'b0, TMR_PRE}, 32'd3);
`else
    check("t1_pre0", {16'b0, TMR_PRE}, 32'd0);
`endif
    for (int k = 1; k <= 6; k++) begin
      ovf_pulse($sformatf("t1_ovf%0d", k));
      apb_rd(A_STATUS, s);
      if (k < 6) begin
        check($sformatf("t1_cmp_k%0d", k), TMR_CMP, exp_cmp[k]);
        check($sformatf("t1_load_k%0d", k), TMR_LOAD, exp_load[k]);
      end
      if (k == 2) check("t1_wrap_early", {31'b0, s[3]}, 32'd0);
      if (k == 3) check("t1_wrap_set", {31'b0, s[3]}, 32'd1);
      if (k == 5) check("t1_done_early", {31'b0, s[2]}, 32'd0);
`ifdef TMR_SEQ_PRESCALE_EN
      if (k == 1) check("t1_pre1", {16'b0, TMR_PRE}, 32'd7);
`endif
    end
    check("t1_done", {31'b0, s[2]}, 32'd1);
    check("t1_idle", {30'b0, s[1:0]}, 32'd0);
    check("t1_pass", {24'b0, s[23:16]}, 32'd2);
    check("t1_en_off", {31'b0, TMR_EN}, 32'd0);

    // Free-running: REPEAT=0, COUNT=2
    apb_wr(A_IC, 32'd3);
    apb_wr(A_COUNT, 32'd2);
    apb_wr(A_REPEAT, 32'd0);
    apb_wr(A_CTRL, 32'd1);
    cycles(2);
    apb_rd(A_STATUS, s);
    check("t2_ptr0", {28'b0, s[11:8]}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      ovf_pulse($sformatf("t2_ovf%0d", k));
      apb_rd(A_STATUS, s);
      check($sformatf("t2_ptr_k%0d", k), {28'b0, s[11:8]}, {28'b0, exp_ptr[k]});
    end
    check("t2_pass", {24'b0, s[23:16]}, 32'd2);
    check("t2_nodone", {31'b0, s[2]}, 32'd0);
    apb_wr(A_CTRL, 32'd2);
    check("t2_en_before_stop", {31'b0, TMR_EN}, 32'd1);
    cycles(1);
    apb_rd(A_STATUS, s);
    check("t2_stop_en", {31'b0, TMR_EN}, 32'd0);
    check("t2_stop_idle", {30'b0, s[1:0]}, 32'd0);
    check("t2_stop_nodone", {31'b0, s[2]}, 32'd0);

    // COUNT=0 start is ignored
    apb_wr(A_COUNT, 32'd0);
    apb_wr(A_CTRL, 32'd1);
    cycles(3);
    apb_rd(A_STATUS, s);
    check("t3_idle", {30'b0, s[1:0]}, 32'd0);
    check("t3_en", {31'b0, TMR_EN}, 32'd0);

    // Interrupt mask and clear
    apb_wr(A_IC, 32'd3);
    apb_wr(A_IM, 32'd1);
    apb_wr(A_COUNT, 32'd1);
    apb_wr(A_REPEAT, 32'd1);
    apb_wr(A_CTRL, 32'd1);
    cycles(2);
    check("t4_pirq_pre", {31'b0, PIRQ}, 32'd0);
    ovf_pulse("t4_ovf");
    apb_rd(A_STATUS, s);
    check("t4_done", {31'b0, s[2]}, 32'd1);
    check("t4_pirq", {31'b0, PIRQ}, 32'd1);
    apb_wr(A_IC, 32'd1);
    check("t4_pirq_clr", {31'b0, PIRQ}, 32'd0);
    // IC write lands on the same edge that leaves ADV and sets DONE
    apb_wr(A_CTRL, 32'd1);
    cycles(2);
    TMR_OVF = 1'b1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = A_IC; PWDATA = 32'd1;
    @(negedge PCLK);
    TMR_OVF = 1'b0;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_rd(A_STATUS, s);
    check("t4_set_wins", {31'b0, s[2]}, 32'd1);
    check("t4_set_wins_pirq", {31'b0, PIRQ}, 32'd1);

    // STOP+START together while idle, then reset mid-run
    apb_wr(A_COUNT, 32'd2);
    apb_wr(A_CTRL, 32'd3);
    cycles(3);
    apb_rd(A_STATUS, s);
    check("t5_both_idle", {30'b0, s[1:0]}, 32'd0);
    check("t5_both_en", {31'b0, TMR_EN}, 32'd0);
    apb_wr(A_CTRL, 32'd1);
    cycles(3);
    check("t5_running", {31'b0, TMR_EN}, 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("t5_async_en", {31'b0, TMR_EN}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    cycles(1);
    apb_rd(A_STATUS, s);
    check("t5_status_rst", s, 32'd0);
    apb_rd(A_COUNT, s);
    check("t5_count_rst", s, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
